// File: rtl/adder_vector_checker.sv
// Operand sequencer and result checker for a combinational WIDTH-bit adder under test.
// Drives a fixed operand sequence, samples the truncated sum and reports pass/fail statistics.
module adder_vector_checker #(
    parameter int WIDTH   = 4,
    parameter int NUM_VEC = 8,
    parameter int SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] sum_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic             fail_valid,
    output logic [7:0]       first_fail
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_K      = 8'(NUM_VEC - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state_reg, state_next;
    logic [7:0]       k_reg, k_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [7:0]       err_reg, err_next;
    logic             fv_reg, fv_next;
    logic [7:0]       ff_reg, ff_next;

    logic [WIDTH-1:0] exp_sum;
    logic [WIDTH-1:0] bit_match;
    logic             mismatch;

    // Operands are closed-form in the index, so no vector table is needed.
    function automatic logic [WIDTH-1:0] vec_a(input logic [7:0] idx);
        logic [10:0] t;
        t = {3'b000, idx} * 11'd3 + 11'd5;
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] vec_b(input logic [7:0] idx);
        logic [10:0] t;
        t = {3'b000, idx} * 11'd7 + 11'd6;
        return t[WIDTH-1:0];
    endfunction

    assign exp_sum = a_reg + b_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_cmp
        assign bit_match[gi] = (sum_in[gi] == exp_sum[gi]);
    end

    // Defaulting to mismatch makes an unknown sum count as a failure.
    always_comb begin
        mismatch = 1'b1;
        if (&bit_match) mismatch = 1'b0;
    end

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        err_next   = err_reg;
        fv_next    = fv_reg;
        ff_next    = ff_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_DRIVE;
                    k_next     = 8'd0;
                    cnt_next   = 4'd0;
                    a_next     = vec_a(8'd0);
                    b_next     = vec_b(8'd0);
                    err_next   = 8'd0;
                    fv_next    = 1'b0;
                    ff_next    = 8'd0;
                end
            end
            S_DRIVE: begin
                if (cnt_reg == SETTLE_LAST) state_next = S_CHECK;
                else                        cnt_next   = cnt_reg + 4'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_reg != 8'hFF) err_next = err_reg + 8'd1;
                    if (!fv_reg) begin
                        fv_next = 1'b1;
                        ff_next = k_reg;
                    end
                end
                if (k_reg == LAST_K) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_DRIVE;
                    k_next     = k_reg + 8'd1;
                    cnt_next   = 4'd0;
                    a_next     = vec_a(k_reg + 8'd1);
                    b_next     = vec_b(k_reg + 8'd1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            k_reg     <= 8'd0;
            cnt_reg   <= 4'd0;
            a_reg     <= '0;
            b_reg     <= '0;
            err_reg   <= 8'd0;
            fv_reg    <= 1'b0;
            ff_reg    <= 8'd0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            err_reg   <= err_next;
            fv_reg    <= fv_next;
            ff_reg    <= ff_next;
        end
    end

    assign a_out      = a_reg;
    assign b_out      = b_reg;
    assign busy       = (state_reg == S_DRIVE) || (state_reg == S_CHECK);
    assign done       = (state_reg == S_DONE);
    assign pass       = done && (err_reg == 8'd0);
    assign err_count  = err_reg;
    assign fail_valid = fv_reg;
    assign first_fail = ff_reg;

endmodule

// File: tb/tb_adder_vector_checker.sv
// Bench for adder_vector_checker: a 4-bit/8-vector instance with a fault-injectable adder,
// an 8-bit/256-vector instance with the sum tied low, and a single-vector instance.
module tb_adder_vector_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance: WIDTH=4, NUM_VEC=8, SETTLE=1, with a modelled adder.
    logic       start_m = 1'b0;
    logic [3:0] a_m, b_m, sum_m, raw_m;
    logic       busy_m, done_m, pass_m, fv_m;
    logic [7:0] err_m, ff_m;
    int         fault_mode = 0;

    assign raw_m = a_m + b_m;
    assign sum_m = (fault_mode == 1) ? {raw_m[3:1], 1'b0} : raw_m;

    adder_vector_checker #(.WIDTH(4), .NUM_VEC(8), .SETTLE(1)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .a_out(a_m), .b_out(b_m), .sum_in(sum_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
        .fail_valid(fv_m), .first_fail(ff_m)
    );

    // Wide instance with the sum stuck at zero.
    logic       start_w = 1'b0;
    logic [7:0] a_w, b_w;
    logic       busy_w, done_w, pass_w, fv_w;
    logic [7:0] err_w, ff_w;

    adder_vector_checker #(.WIDTH(8), .NUM_VEC(256), .SETTLE(2)) dut_w (
        .clk(clk), .rst(rst), .start(start_w), .a_out(a_w), .b_out(b_w), .sum_in(8'd0),
        .busy(busy_w), .done(done_w), .pass(pass_w), .err_count(err_w),
        .fail_valid(fv_w), .first_fail(ff_w)
    );

    // Single-vector instance with a directly driven sum.
    logic       start_n = 1'b0;
    logic [3:0] a_n, b_n;
    logic [3:0] sum_n = 4'd0;
    logic       busy_n, done_n, pass_n, fv_n;
    logic [7:0] err_n, ff_n;

    adder_vector_checker #(.WIDTH(4), .NUM_VEC(1), .SETTLE(1)) dut_n (
        .clk(clk), .rst(rst), .start(start_n), .a_out(a_n), .b_out(b_n), .sum_in(sum_n),
        .busy(busy_n), .done(done_n), .pass(pass_n), .err_count(err_n),
        .fail_valid(fv_n), .first_fail(ff_n)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] e;
    } vec_t;

    vec_t tbl[8];
    vec_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_main(input string tag);
        check({tag, "_a"},    32'(a_m), 32'd0);
        check({tag, "_b"},    32'(b_m), 32'd0);
        check({tag, "_busy"}, 32'(busy_m), 32'd0);
        check({tag, "_done"}, 32'(done_m), 32'd0);
        check({tag, "_pass"}, 32'(pass_m), 32'd0);
        check({tag, "_err"},  32'(err_m), 32'd0);
        check({tag, "_fv"},   32'(fv_m), 32'd0);
        check({tag, "_ff"},   32'(ff_m), 32'd0);
    endtask

    // One full main-instance run; expected operands are queued at start and popped per vector.
    task automatic run_main(input int exp_err, input logic [7:0] exp_ff, input bit poke);
        vec_t v;
        for (int k = 0; k < 8; k++) sb_q.push_back(tbl[k]);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            start_m = (poke && (c == 3 || c == 9)) ? 1'b1 : 1'b0;
            if (c == 1) begin
                check("run_start_err", 32'(err_m), 32'd0);
                check("run_start_fv",  32'(fv_m), 32'd0);
            end
            if (c < 17) begin
                check("run_busy_done", 32'({busy_m, done_m}), 32'b10);
                if ((c - 1) % 2 == 0) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        v = sb_q.pop_front();
                        $display("vector %0d: a_out=%b b_out=%b expect a=%b b=%b e=%b",
                                 (c - 1) / 2, a_m, b_m, v.a, v.b, v.e);
                        check("vec_a", 32'(a_m), 32'(v.a));
                        check("vec_b", 32'(b_m), 32'(v.b));
                    end
                end
            end else begin
                check("end_busy_done", 32'({busy_m, done_m}), 32'b01);
                check("end_pass",      32'(pass_m), 32'(exp_err == 0));
                check("end_err",       32'(err_m), 32'(exp_err));
                check("end_fv",        32'(fv_m), 32'(exp_err != 0));
                check("end_ff",        32'(ff_m), 32'(exp_ff));
                check("end_a_hold",    32'(a_m), 32'(tbl[7].a));
                check("end_b_hold",    32'(b_m), 32'(tbl[7].b));
            end
            @(negedge clk);
        end
        start_m = 1'b0;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("main run done: err_count=%0d first_fail=%0d pass=%0b", err_m, ff_m, pass_m);
    endtask

    initial begin
        int odd_cnt;
        // a=(3k+5)%16, b=(7k+6)%16, e=(a+b)%16
        tbl[0] = '{4'd5,  4'd6,  4'd11};
        tbl[1] = '{4'd8,  4'd13, 4'd5};
        tbl[2] = '{4'd11, 4'd4,  4'd15};
        tbl[3] = '{4'd14, 4'd11, 4'd9};
        tbl[4] = '{4'd1,  4'd2,  4'd3};
        tbl[5] = '{4'd4,  4'd9,  4'd13};
        tbl[6] = '{4'd7,  4'd0,  4'd7};
        tbl[7] = '{4'd10, 4'd7,  4'd1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_main("reset");
        check("reset_w_busy_done", 32'({busy_w, done_w}), 32'd0);
        check("reset_n_busy_done", 32'({busy_n, done_n}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_stays", 32'({busy_m, done_m}), 32'd0);

        // Correct adder.
        fault_mode = 0;
        run_main(0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("done_level", 32'(done_m), 32'd1);

        // Sum bit 0 stuck at zero, restarted from DONE.
        fault_mode = 1;
        odd_cnt = 0;
        for (int k = 0; k < 8; k++) if (tbl[k].e[0]) odd_cnt++;
        run_main(odd_cnt, 8'd0, 1'b0);

        // Restart after a failing run, with start pokes during busy that must be ignored.
        fault_mode = 0;
        repeat (3) @(negedge clk);
        run_main(0, 8'd0, 1'b1);

        // Reset mid-run discards partial (faulty) results.
        fault_mode = 1;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_busy", 32'(busy_m), 32'd1);
        check("midrun_err",  32'(err_m), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_main("midrun_reset");
        fault_mode = 0;
        run_main(0, 8'd0, 1'b0);

        // Wide instance: 256 mismatches saturate the counter at 255.
        start_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        check("w_first_a", 32'(a_w), 32'd5);
        check("w_first_b", 32'(b_w), 32'd6);
        repeat (767) @(negedge clk);
        check("w_768_busy_done", 32'({busy_w, done_w}), 32'b10);
        @(negedge clk);
        check("w_769_busy_done", 32'({busy_w, done_w}), 32'b01);
        check("w_err_sat", 32'(err_w), 32'd255);
        check("w_ff",      32'(ff_w), 32'd0);
        check("w_fv",      32'(fv_w), 32'd1);
        check("w_pass",    32'(pass_w), 32'd0);
        check("w_last_a",  32'(a_w), 32'd2);
        check("w_last_b",  32'(b_w), 32'd255);
        $display("wide run done: err_count=%0d first_fail=%0d", err_w, ff_w);

        // Single vector, correct sum; later sum changes must not count.
        sum_n = 4'd11;
        start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        check("n_c1_a", 32'(a_n), 32'd5);
        check("n_c1_busy_done", 32'({busy_n, done_n}), 32'b10);
        @(negedge clk);
        check("n_c2_busy_done", 32'({busy_n, done_n}), 32'b10);
        @(negedge clk);
        check("n_c3_busy_done", 32'({busy_n, done_n}), 32'b01);
        sum_n = 4'd0;
        repeat (2) @(negedge clk);
        check("n_hold_err",  32'(err_n), 32'd0);
        check("n_hold_pass", 32'(pass_n), 32'd1);
        $display("single run 1 done: err_count=%0d", err_n);

        // Single vector, wrong sum; a later correct sum must not clear it.
        start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        repeat (2) @(negedge clk);
        check("n2_done", 32'(done_n), 32'd1);
        check("n2_err",  32'(err_n), 32'd1);
        check("n2_ff",   32'(ff_n), 32'd0);
        check("n2_fv",   32'(fv_n), 32'd1);
        check("n2_pass", 32'(pass_n), 32'd0);
        sum_n = 4'd11;
        repeat (2) @(negedge clk);
        check("n2_hold_err", 32'(err_n), 32'd1);
        $display("single run 2 done: err_count=%0d", err_n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
